id_ctrl_stage: RTL and testbench

//  Registered ID-stage control unit for the 5-stage MIPS pipeline.

---
 rtl/id_ctrl_stage_pkg.sv | 109 ++++++++++
 rtl/id_ctrl_stage_ctrl_decode.sv | 135 +++++++++++++
 rtl/id_ctrl_stage.sv | 118 +++++++++++
 tb/tb_id_ctrl_stage.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ctrl_stage_pkg.sv
// rtl/id_ctrl_stage_pkg.sv - shared encodings and control word for the ID control stage
package id_ctrl_stage_pkg;

  localparam int CTRL_SEL_W = 2;
  localparam int ALU_W      = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_SLL   = 6'h00;
  localparam logic [5:0] FUNCT_SRL   = 6'h02;
  localparam logic [5:0] FUNCT_SRA   = 6'h03;
  localparam logic [5:0] FUNCT_SLLV  = 6'h04;
  localparam logic [5:0] FUNCT_SRLV  = 6'h06;
  localparam logic [5:0] FUNCT_SRAV  = 6'h07;
  localparam logic [5:0] FUNCT_JR    = 6'h08;
  localparam logic [5:0] FUNCT_JALR  = 6'h09;
  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
  localparam logic [5:0] FUNCT_ADD   = 6'h20;
  localparam logic [5:0] FUNCT_ADDU  = 6'h21;
  localparam logic [5:0] FUNCT_SUB   = 6'h22;
  localparam logic [5:0] FUNCT_SUBU  = 6'h23;
  localparam logic [5:0] FUNCT_AND   = 6'h24;
  localparam logic [5:0] FUNCT_OR    = 6'h25;
  localparam logic [5:0] FUNCT_XOR   = 6'h26;
  localparam logic [5:0] FUNCT_NOR   = 6'h27;
  localparam logic [5:0] FUNCT_SLT   = 6'h2A;
  localparam logic [5:0] FUNCT_SLTU  = 6'h2B;

  localparam logic [4:0] ALUOP_NOP   = 5'd0;
  localparam logic [4:0] ALUOP_ADD   = 5'd1;
  localparam logic [4:0] ALUOP_SUB   = 5'd2;
  localparam logic [4:0] ALUOP_AND   = 5'd3;
  localparam logic [4:0] ALUOP_OR    = 5'd4;
  localparam logic [4:0] ALUOP_XOR   = 5'd5;
  localparam logic [4:0] ALUOP_NOR   = 5'd6;
  localparam logic [4:0] ALUOP_SLT   = 5'd7;
  localparam logic [4:0] ALUOP_SLTU  = 5'd8;
  localparam logic [4:0] ALUOP_SLL   = 5'd9;
  localparam logic [4:0] ALUOP_SRL   = 5'd10;
  localparam logic [4:0] ALUOP_SRA   = 5'd11;
  localparam logic [4:0] ALUOP_SLLV  = 5'd12;
  localparam logic [4:0] ALUOP_SRLV  = 5'd13;
  localparam logic [4:0] ALUOP_SRAV  = 5'd14;
  localparam logic [4:0] ALUOP_LUI   = 5'd15;
  localparam logic [4:0] ALUOP_MULT  = 5'd16;
  localparam logic [4:0] ALUOP_MULTU = 5'd17;
  localparam logic [4:0] ALUOP_DIV   = 5'd18;
  localparam logic [4:0] ALUOP_DIVU  = 5'd19;
  localparam logic [4:0] ALUOP_MFHI  = 5'd20;
  localparam logic [4:0] ALUOP_MFLO  = 5'd21;

  localparam logic [1:0] REGDST_RT     = 2'b00;
  localparam logic [1:0] REGDST_RD     = 2'b01;
  localparam logic [1:0] REGDST_RA     = 2'b10;
  localparam logic [1:0] ALUSRCA_RS    = 2'b00;
  localparam logic [1:0] ALUSRCA_SHAMT = 2'b01;
  localparam logic [1:0] ALUSRCB_RT    = 2'b00;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b01;
  localparam logic [1:0] EXTOP_ZERO    = 2'b00;
  localparam logic [1:0] EXTOP_SIGN    = 2'b01;
  localparam logic [1:0] MEMTOREG_ALU  = 2'b00;
  localparam logic [1:0] MEMTOREG_MEM  = 2'b01;
  localparam logic [1:0] MEMTOREG_LINK = 2'b10;
  localparam logic [1:0] JUMP_NONE     = 2'b00;
  localparam logic [1:0] JUMP_J        = 2'b01;
  localparam logic [1:0] JUMP_REG      = 2'b10;
  localparam logic [1:0] JUMP_BRANCH   = 2'b11;

  typedef enum logic {MD_IDLE = 1'b0, MD_BUSY = 1'b1} md_state_t;

  typedef struct packed {
    logic [CTRL_SEL_W-1:0] reg_dst;
    logic [CTRL_SEL_W-1:0] alu_src_a;
    logic [CTRL_SEL_W-1:0] alu_src_b;
    logic [CTRL_SEL_W-1:0] ext_op;
    logic [CTRL_SEL_W-1:0] mem_to_reg;
    logic [CTRL_SEL_W-1:0] jump;
    logic [ALU_W-1:0]      alu_op;
    logic                  mem_read;
    logic                  mem_write;
    logic                  reg_write;
  } ctrl_t;

endpackage

// File: rtl/id_ctrl_stage_ctrl_decode.sv
// rtl/id_ctrl_stage_ctrl_decode.sv - combinational opcode/funct to control word decoder
module ctrl_decode
  import id_ctrl_stage_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output ctrl_t      ctrl,
  output logic       illegal,
  output logic       uses_rs,
  output logic       uses_rt,
  output logic       is_md,
  output logic       is_mf
);

  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    is_md   = 1'b0;
    is_mf   = 1'b0;
    case (op)
      OP_RTYPE: begin
        ctrl.reg_dst   = REGDST_RD;
        ctrl.reg_write = 1'b1;
        uses_rs        = 1'b1;
        uses_rt        = 1'b1;
        case (funct)
          FUNCT_ADD, FUNCT_ADDU: ctrl.alu_op = ALUOP_ADD;
          FUNCT_SUB, FUNCT_SUBU: ctrl.alu_op = ALUOP_SUB;
          FUNCT_AND:  ctrl.alu_op = ALUOP_AND;
          FUNCT_OR:   ctrl.alu_op = ALUOP_OR;
          FUNCT_XOR:  ctrl.alu_op = ALUOP_XOR;
          FUNCT_NOR:  ctrl.alu_op = ALUOP_NOR;
          FUNCT_SLT:  ctrl.alu_op = ALUOP_SLT;
          FUNCT_SLTU: ctrl.alu_op = ALUOP_SLTU;
          FUNCT_SLLV: ctrl.alu_op = ALUOP_SLLV;
          FUNCT_SRLV: ctrl.alu_op = ALUOP_SRLV;
          FUNCT_SRAV: ctrl.alu_op = ALUOP_SRAV;
          FUNCT_SLL, FUNCT_SRL, FUNCT_SRA: begin
            // Immediate shifts take shamt on port A and never touch rs.
            ctrl.alu_src_a = ALUSRCA_SHAMT;
            ctrl.alu_op    = (funct == FUNCT_SLL) ? ALUOP_SLL :
                             (funct == FUNCT_SRL) ? ALUOP_SRL : ALUOP_SRA;
            uses_rs        = 1'b0;
          end
          FUNCT_JR: begin
            ctrl.reg_dst   = REGDST_RT;
            ctrl.reg_write = 1'b0;
            ctrl.jump      = JUMP_REG;
            uses_rt        = 1'b0;
          end
          FUNCT_JALR: begin
            ctrl.jump       = JUMP_REG;
            ctrl.mem_to_reg = MEMTOREG_LINK;
            uses_rt         = 1'b0;
          end
          FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU: begin
            ctrl.reg_dst   = REGDST_RT;
            ctrl.reg_write = 1'b0;
            ctrl.alu_op    = (funct == FUNCT_MULT)  ? ALUOP_MULT  :
                             (funct == FUNCT_MULTU) ? ALUOP_MULTU :
                             (funct == FUNCT_DIV)   ? ALUOP_DIV   : ALUOP_DIVU;
            is_md          = 1'b1;
          end
          FUNCT_MFHI, FUNCT_MFLO: begin
            ctrl.alu_op = (funct == FUNCT_MFHI) ? ALUOP_MFHI : ALUOP_MFLO;
            uses_rs     = 1'b0;
            uses_rt     = 1'b0;
            is_mf       = 1'b1;
          end
          default: begin
            ctrl    = '0;
            uses_rs = 1'b0;
            uses_rt = 1'b0;
            illegal = 1'b1;
          end
        endcase
      end
      OP_J: ctrl.jump = JUMP_J;
      OP_JAL: begin
        ctrl.jump       = JUMP_J;
        ctrl.reg_dst    = REGDST_RA;
        ctrl.mem_to_reg = MEMTOREG_LINK;
        ctrl.reg_write  = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        ctrl.jump   = JUMP_BRANCH;
        ctrl.ext_op = EXTOP_SIGN;
        ctrl.alu_op = ALUOP_SUB;
        uses_rs     = 1'b1;
        uses_rt     = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
        ctrl.alu_src_b = ALUSRCB_IMM;
        ctrl.reg_write = 1'b1;
        uses_rs        = 1'b1;
        ctrl.ext_op    = (op == OP_ANDI || op == OP_ORI || op == OP_XORI) ? EXTOP_ZERO : EXTOP_SIGN;
        case (op)
          OP_SLTI:  ctrl.alu_op = ALUOP_SLT;
          OP_SLTIU: ctrl.alu_op = ALUOP_SLTU;
          OP_ANDI:  ctrl.alu_op = ALUOP_AND;
          OP_ORI:   ctrl.alu_op = ALUOP_OR;
          OP_XORI:  ctrl.alu_op = ALUOP_XOR;
          default:  ctrl.alu_op = ALUOP_ADD;
        endcase
      end
      OP_LUI: begin
        ctrl.alu_src_b = ALUSRCB_IMM;
        ctrl.ext_op    = EXTOP_ZERO;
        ctrl.alu_op    = ALUOP_LUI;
        ctrl.reg_write = 1'b1;
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        ctrl.alu_src_b  = ALUSRCB_IMM;
        ctrl.ext_op     = EXTOP_SIGN;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = MEMTOREG_MEM;
        ctrl.reg_write  = 1'b1;
        uses_rs         = 1'b1;
      end
      OP_SB, OP_SH, OP_SW: begin
        ctrl.alu_src_b = ALUSRCB_IMM;
        ctrl.ext_op    = EXTOP_SIGN;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.mem_write = 1'b1;
        uses_rs        = 1'b1;
        uses_rt        = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ctrl_stage.sv
// rtl/id_ctrl_stage.sv - registered ID control stage with load-use and HI/LO interlocks
module id_ctrl_stage
  import id_ctrl_stage_pkg::*;
#(
  parameter int MD_LATENCY = 32,
  parameter int ALUOP_W    = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [31:0]        in_instr,
  output logic               in_ready,
  input  logic               flush,
  input  logic               ex_memread,
  input  logic [4:0]         ex_wreg,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_instr,
  output logic [1:0]         out_RegDst,
  output logic [1:0]         out_ALUSrcA,
  output logic [1:0]         out_ALUSrcB,
  output logic [1:0]         out_EXTOp,
  output logic [1:0]         out_MemtoReg,
  output logic [1:0]         out_Jump,
  output logic [ALUOP_W-1:0] out_ALUOp,
  output logic               out_MemRead,
  output logic               out_MemWrite,
  output logic               out_RegWrite,
  output logic               out_illegal,
  output logic               md_busy
);

  localparam logic [7:0] MD_RELOAD = 8'(MD_LATENCY - 1);

  ctrl_t      dec_ctrl;
  ctrl_t      out_ctrl;
  logic       dec_illegal, dec_rs, dec_rt, dec_md, dec_mf;
  logic       out_md;
  logic       ld, lu_hazard, mf_hazard, stall, md_start;
  md_state_t  md_state, md_next;
  logic [7:0] md_cnt;

  ctrl_decode u_decode (
    .op      (in_instr[31:26]),
    .funct   (in_instr[5:0]),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal),
    .uses_rs (dec_rs),
    .uses_rt (dec_rt),
    .is_md   (dec_md),
    .is_mf   (dec_mf)
  );

  always_comb begin
    ld        = ~out_valid | out_ready;
    lu_hazard = ex_memread && (ex_wreg != 5'd0) &&
                ((dec_rs && in_instr[25:21] == ex_wreg) || (dec_rt && in_instr[20:16] == ex_wreg));
    // MFHI/MFLO must wait until any multiply/divide ahead of it has fully drained.
    mf_hazard = dec_mf && (md_busy || (out_valid && out_md));
    stall     = lu_hazard | mf_hazard;
    in_ready  = ld & ~stall & ~flush;
    md_start  = out_valid & out_ready & ~flush & out_md;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_instr   <= '0;
      out_ctrl    <= '0;
      out_illegal <= 1'b0;
      out_md      <= 1'b0;
    end else if (ld) begin
      out_valid   <= in_valid & ~stall & ~flush;
      out_instr   <= in_instr;
      out_ctrl    <= dec_ctrl;
      out_illegal <= dec_illegal;
      out_md      <= dec_md;
    end else if (flush) begin
      out_valid   <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) md_state <= MD_IDLE;
    else     md_state <= md_next;
  end

  always_comb begin
    md_next = md_state;
    case (md_state)
      MD_IDLE: if (md_start) md_next = MD_BUSY;
      MD_BUSY: if (!md_start && md_cnt == 8'd0) md_next = MD_IDLE;
      default: md_next = MD_IDLE;
    endcase
  end

  always_comb begin
    md_busy = (md_state == MD_BUSY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     md_cnt <= 8'd0;
    else if (md_start)                           md_cnt <= MD_RELOAD;
    else if (md_state == MD_BUSY && md_cnt != 0) md_cnt <= md_cnt - 8'd1;
  end

  assign out_RegDst   = out_ctrl.reg_dst;
  assign out_ALUSrcA  = out_ctrl.alu_src_a;
  assign out_ALUSrcB  = out_ctrl.alu_src_b;
  assign out_EXTOp    = out_ctrl.ext_op;
  assign out_MemtoReg = out_ctrl.mem_to_reg;
  assign out_Jump     = out_ctrl.jump;
  assign out_ALUOp    = ALUOP_W'(out_ctrl.alu_op);
  assign out_MemRead  = out_ctrl.mem_read;
  assign out_MemWrite = out_ctrl.mem_write;
  assign out_RegWrite = out_ctrl.reg_write;

endmodule

// File: tb/tb_id_ctrl_stage.sv
// tb/tb_id_ctrl_stage.sv - directed and randomized checks of id_ctrl_stage against a cycle model
module tb_id_ctrl_stage;
  import id_ctrl_stage_pkg::*;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic        ex_memread = 1'b0;
  logic [4:0]  ex_wreg = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [1:0]  out_RegDst, out_ALUSrcA, out_ALUSrcB, out_EXTOp, out_MemtoReg, out_Jump;
  logic [4:0]  out_ALUOp;
  logic        out_MemRead, out_MemWrite, out_RegWrite, out_illegal, md_busy;

  int checks = 0;
  int errors = 0;

  logic        m_valid = 1'b0;
  logic [31:0] m_instr = '0;
  int          m_edge = 0;
  int          m_last = 0;
  bit          m_seen = 1'b0;
  logic        last_ready;

  logic [5:0] r_pool [25] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
                              6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09,
                              6'h10, 6'h12, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h3F};
  logic [5:0] i_pool [22] = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C,
                              6'h0D, 6'h0E, 6'h0F, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28,
                              6'h29, 6'h2B, 6'h3F, 6'h07};

  id_ctrl_stage #(.MD_LATENCY(LAT), .ALUOP_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .flush(flush), .ex_memread(ex_memread), .ex_wreg(ex_wreg), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_RegDst(out_RegDst),
    .out_ALUSrcA(out_ALUSrcA), .out_ALUSrcB(out_ALUSrcB), .out_EXTOp(out_EXTOp),
    .out_MemtoReg(out_MemtoReg), .out_Jump(out_Jump), .out_ALUOp(out_ALUOp),
    .out_MemRead(out_MemRead), .out_MemWrite(out_MemWrite), .out_RegWrite(out_RegWrite),
    .out_illegal(out_illegal), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] pk(input logic [1:0] rd, sa, sb, ex, mtr, j,
                                     input logic [4:0] alu, input logic mr, mw, rw);
    return {rd, sa, sb, ex, mtr, j, alu, mr, mw, rw};
  endfunction

  function automatic logic [4:0] alu_of(input logic [5:0] fn);
    case (fn)
      FUNCT_ADD, FUNCT_ADDU: return ALUOP_ADD;
      FUNCT_SUB, FUNCT_SUBU: return ALUOP_SUB;
      FUNCT_AND: return ALUOP_AND;   FUNCT_OR: return ALUOP_OR;
      FUNCT_XOR: return ALUOP_XOR;   FUNCT_NOR: return ALUOP_NOR;
      FUNCT_SLT: return ALUOP_SLT;   FUNCT_SLTU: return ALUOP_SLTU;
      FUNCT_SLL: return ALUOP_SLL;   FUNCT_SRL: return ALUOP_SRL;   FUNCT_SRA: return ALUOP_SRA;
      FUNCT_SLLV: return ALUOP_SLLV; FUNCT_SRLV: return ALUOP_SRLV; FUNCT_SRAV: return ALUOP_SRAV;
      FUNCT_MULT: return ALUOP_MULT; FUNCT_MULTU: return ALUOP_MULTU;
      FUNCT_DIV: return ALUOP_DIV;   FUNCT_DIVU: return ALUOP_DIVU;
      FUNCT_MFHI: return ALUOP_MFHI; FUNCT_MFLO: return ALUOP_MFLO;
      default: return ALUOP_NOP;
    endcase
  endfunction

  // Instruction-class table: expected control word plus which sources are really read.
  task automatic ref_decode(input logic [31:0] i, output logic [19:0] w,
                            output bit ill, output bit rsu, output bit rtu, output bit md, output bit mf);
    logic [5:0] op, fn;
    op = i[31:26]; fn = i[5:0];
    w = '0; ill = 0; rsu = 0; rtu = 0; md = 0; mf = 0;
    if (op == OP_RTYPE) begin
      if (fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h04, 6'h06, 6'h07}) begin
        w = pk(REGDST_RD, ALUSRCA_RS, ALUSRCB_RT, EXTOP_ZERO, MEMTOREG_ALU, JUMP_NONE, alu_of(fn), 0, 0, 1);
        rsu = 1; rtu = 1;
      end else if (fn inside {6'h00, 6'h02, 6'h03}) begin
        w = pk(REGDST_RD, ALUSRCA_SHAMT, ALUSRCB_RT, EXTOP_ZERO, MEMTOREG_ALU, JUMP_NONE, alu_of(fn), 0, 0, 1);
        rtu = 1;
      end else if (fn == FUNCT_JR) begin
        w = pk(REGDST_RT, 0, 0, 0, MEMTOREG_ALU, JUMP_REG, ALUOP_NOP, 0, 0, 0); rsu = 1;
      end else if (fn == FUNCT_JALR) begin
        w = pk(REGDST_RD, 0, 0, 0, MEMTOREG_LINK, JUMP_REG, ALUOP_NOP, 0, 0, 1); rsu = 1;
      end else if (fn inside {6'h18, 6'h19, 6'h1A, 6'h1B}) begin
        w = pk(REGDST_RT, 0, 0, 0, 0, JUMP_NONE, alu_of(fn), 0, 0, 0); rsu = 1; rtu = 1; md = 1;
      end else if (fn inside {6'h10, 6'h12}) begin
        w = pk(REGDST_RD, 0, 0, 0, 0, JUMP_NONE, alu_of(fn), 0, 0, 1); mf = 1;
      end else ill = 1;
    end else if (op == OP_J) w = pk(0, 0, 0, 0, 0, JUMP_J, ALUOP_NOP, 0, 0, 0);
    else if (op == OP_JAL) w = pk(REGDST_RA, 0, 0, 0, MEMTOREG_LINK, JUMP_J, ALUOP_NOP, 0, 0, 1);
    else if (op inside {6'h04, 6'h05}) begin
      w = pk(0, 0, ALUSRCB_RT, EXTOP_SIGN, 0, JUMP_BRANCH, ALUOP_SUB, 0, 0, 0); rsu = 1; rtu = 1;
    end else if (op inside {6'h08, 6'h09, 6'h0A, 6'h0B}) begin
      w = pk(REGDST_RT, 0, ALUSRCB_IMM, EXTOP_SIGN, 0, 0,
             (op == OP_SLTI) ? ALUOP_SLT : (op == OP_SLTIU) ? ALUOP_SLTU : ALUOP_ADD, 0, 0, 1);
      rsu = 1;
    end else if (op inside {6'h0C, 6'h0D, 6'h0E}) begin
      w = pk(REGDST_RT, 0, ALUSRCB_IMM, EXTOP_ZERO, 0, 0,
             (op == OP_ANDI) ? ALUOP_AND : (op == OP_ORI) ? ALUOP_OR : ALUOP_XOR, 0, 0, 1);
      rsu = 1;
    end else if (op == OP_LUI) w = pk(REGDST_RT, 0, ALUSRCB_IMM, EXTOP_ZERO, 0, 0, ALUOP_LUI, 0, 0, 1);
    else if (op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25}) begin
      w = pk(REGDST_RT, 0, ALUSRCB_IMM, EXTOP_SIGN, MEMTOREG_MEM, 0, ALUOP_ADD, 1, 0, 1); rsu = 1;
    end else if (op inside {6'h28, 6'h29, 6'h2B}) begin
      w = pk(0, 0, ALUSRCB_IMM, EXTOP_SIGN, 0, 0, ALUOP_ADD, 0, 1, 0); rsu = 1; rtu = 1;
    end else ill = 1;
  endtask

  function automatic logic [19:0] obs_word();
    return {out_RegDst, out_ALUSrcA, out_ALUSrcB, out_EXTOp, out_MemtoReg, out_Jump,
            out_ALUOp, out_MemRead, out_MemWrite, out_RegWrite};
  endfunction

  // One clock: inputs are already driven; predict, clock, compare.
  task automatic step();
    logic [19:0] w;
    bit ill, rsu, rtu, md, mf, o_md, busy_now, ld, stall, exp_ready, md_start;
    @(negedge clk);
    ref_decode(in_instr, w, ill, rsu, rtu, md, mf);
    ref_decode(m_instr, w, ill, busy_now, ld, o_md, stall);
    ref_decode(in_instr, w, ill, rsu, rtu, md, mf);
    busy_now  = m_seen && (m_edge - m_last < LAT);
    ld        = !m_valid || out_ready;
    stall     = (ex_memread && ex_wreg != 0 &&
                 ((rsu && in_instr[25:21] == ex_wreg) || (rtu && in_instr[20:16] == ex_wreg))) ||
                (mf && (busy_now || (m_valid && o_md)));
    exp_ready = ld && !stall && !flush;
    md_start  = m_valid && out_ready && !flush && o_md;
    chk("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
    last_ready = in_ready;
    @(posedge clk);
    m_edge++;
    if (md_start) begin m_seen = 1; m_last = m_edge; end
    if (ld) m_instr = in_instr;
    if (flush) m_valid = 0;
    else if (ld) m_valid = in_valid && !stall;
    #1;
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    chk("md_busy", {31'b0, md_busy}, {31'b0, (m_seen && (m_edge - m_last < LAT))});
    if (m_valid) begin
      ref_decode(m_instr, w, ill, rsu, rtu, md, mf);
      chk("out_instr", out_instr, m_instr);
      chk("ctrl_word", {12'b0, obs_word()}, {12'b0, w});
      chk("out_illegal", {31'b0, out_illegal}, {31'b0, ill});
    end
  endtask

  function automatic logic [31:0] rtype(input int rs, rt, rd, sh, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
  endfunction

  function automatic logic [31:0] rand_instr();
    int k;
    k = $urandom_range(0, 9);
    if (k < 5)
      return rtype($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 31), r_pool[$urandom_range(0, 24)]);
    else if (k < 9)
      return {i_pool[$urandom_range(0, 21)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              16'($urandom)};
    else
      return $urandom;
  endfunction

  initial begin
    logic [31:0] ori_i, xori_i, mult_i, mflo_i;
    int k, busy_cnt;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_ctrl_word", {12'b0, obs_word()}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_illegal", {31'b0, out_illegal}, 32'd0);
    chk("rst_md_busy", {31'b0, md_busy}, 32'd0);
    rst = 1'b0;

    // ADDIU $1,$0,-1
    in_valid = 1; out_ready = 1; in_instr = 32'h2401FFFF;
    step();
    chk("t1_aluop", {27'b0, out_ALUOp}, {27'b0, ALUOP_ADD});
    chk("t1_alusrcb", {30'b0, out_ALUSrcB}, 32'd1);
    chk("t1_extop", {30'b0, out_EXTOp}, {30'b0, EXTOP_SIGN});
    chk("t1_regwrite", {31'b0, out_RegWrite}, 32'd1);

    // load-use on rs, on rt of a shift, and an rd-only match
    ex_memread = 1; ex_wreg = 5'd5; in_instr = rtype(5, 6, 3, 0, FUNCT_ADD);
    step();
    chk("t2_stall_ready", {31'b0, last_ready}, 32'd0);
    chk("t2_bubble", {31'b0, out_valid}, 32'd0);
    ex_memread = 0;
    step();
    chk("t2_issue", out_instr, rtype(5, 6, 3, 0, FUNCT_ADD));
    ex_memread = 1; in_instr = rtype(0, 5, 3, 2, FUNCT_SLL);
    step();
    chk("t2_sll_stall", {31'b0, last_ready}, 32'd0);
    in_instr = rtype(1, 2, 5, 0, FUNCT_ADD);
    step();
    chk("t2_rd_only", {31'b0, last_ready}, 32'd1);
    ex_memread = 0;

    // MULT then MFLO back to back
    mult_i = rtype(1, 2, 0, 0, FUNCT_MULT);
    mflo_i = rtype(0, 0, 4, 0, FUNCT_MFLO);
    in_instr = mult_i;
    step();
    in_instr = mflo_i;
    step();
    busy_cnt = md_busy ? 1 : 0;
    k = 0;
    while (k < 20 && !(out_valid && out_instr == mflo_i)) begin
      step();
      k++;
      busy_cnt += md_busy ? 1 : 0;
    end
    chk("t3_mflo_latency", k, 5);
    chk("t3_busy_cycles", busy_cnt, LAT);
    in_valid = 0;
    step();

    // back-pressure: word held, then next loaded on the release edge
    ori_i = {OP_ORI, 5'd1, 5'd2, 16'h0005};
    xori_i = {OP_XORI, 5'd3, 5'd4, 16'h00F0};
    in_valid = 1; in_instr = ori_i;
    step();
    out_ready = 0; in_instr = xori_i;
    for (int n = 0; n < 3; n++) begin
      step();
      chk("t4_hold_ready", {31'b0, last_ready}, 32'd0);
      chk("t4_hold_instr", out_instr, ori_i);
    end
    out_ready = 1;
    step();
    chk("t4_next_loaded", out_instr, xori_i);

    // flush kills a waiting DIV, sequencer never starts
    in_instr = rtype(1, 2, 0, 0, FUNCT_DIV);
    step();
    out_ready = 0; flush = 1; in_instr = rtype(1, 2, 3, 0, FUNCT_ADD);
    step();
    chk("t5_flush_valid", {31'b0, out_valid}, 32'd0);
    chk("t5_flush_busy", {31'b0, md_busy}, 32'd0);
    flush = 0; out_ready = 1; in_valid = 0;
    repeat (2) step();
    chk("t5_still_idle", {31'b0, md_busy}, 32'd0);

    // asynchronous reset in the middle of MD_BUSY
    in_valid = 1; in_instr = mult_i;
    step();
    in_valid = 0;
    repeat (2) step();
    chk("t5_busy_before_rst", {31'b0, md_busy}, 32'd1);
    #2 rst = 1;
    #1;
    chk("t5_rst_busy", {31'b0, md_busy}, 32'd0);
    chk("t5_rst_valid", {31'b0, out_valid}, 32'd0);
    m_valid = 0; m_instr = '0; m_seen = 0;
    @(posedge clk);
    #1 rst = 0;

    // undecodable opcode
    in_valid = 1; in_instr = 32'hFC000000;
    step();
    chk("t6_illegal", {31'b0, out_illegal}, 32'd1);
    chk("t6_regwrite", {31'b0, out_RegWrite}, 32'd0);
    chk("t6_memwrite", {31'b0, out_MemWrite}, 32'd0);
    chk("t6_jump", {30'b0, out_Jump}, 32'd0);

    for (int n = 0; n < 400; n++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_instr   = rand_instr();
      out_ready  = ($urandom_range(0, 9) < 7);
      flush      = ($urandom_range(0, 99) < 8);
      ex_memread = ($urandom_range(0, 9) < 3);
      ex_wreg    = 5'($urandom_range(0, 7));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
